// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider: run control and
// config from the sequencing master, divided clocks and strobes back.
interface clk_div_prog_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]       enable;
  logic                 sync;
  logic [NCH-1:0]       cfg_load;
  logic [NCH*CNT_W-1:0] div_ratio;
  logic [NCH*CNT_W-1:0] high_cnt;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       rise_tick;
  logic [NCH-1:0]       fall_tick;
  logic [NCH-1:0]       cfg_pend;
  logic [NCH-1:0]       cfg_err;

  modport master (
    output enable, sync, cfg_load, div_ratio, high_cnt,
    input  clk_out, rise_tick, fall_tick, cfg_pend, cfg_err
  );

  modport slave (
    input  enable, sync, cfg_load, div_ratio, high_cnt,
    output clk_out, rise_tick, fall_tick, cfg_pend, cfg_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel programmable divider: each channel is N-H cycles low then H high,
// with shadowed config that only takes effect on a period boundary.
module clk_div_prog #(
  parameter int NCH      = 2,
  parameter int CNT_W    = 8,
  parameter int DEF_DIV  = 12,
  parameter int DEF_HIGH = 6
) (
  input logic           clk_50M,
  input logic           rst,
  clk_div_prog_if.slave bus
);
  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d, h_q, h_d;
    logic [CNT_W-1:0] sn_q, sn_d, sh_q, sh_d;
    logic             pend_q, pend_d, err_q, err_d;
    logic             clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
    logic [CNT_W-1:0] ld_n, ld_h;
    logic             ld_ok, apply_ld, run, wrap;

    always_comb begin
      ld_n     = bus.div_ratio[g*CNT_W +: CNT_W];
      ld_h     = bus.high_cnt[g*CNT_W +: CNT_W];
      ld_ok    = (ld_n >= TWO) && (ld_h != '0) && (ld_h < ld_n);
      apply_ld = bus.cfg_load[g] && ld_ok;
      run      = bus.enable[g] && !bus.sync;
      wrap     = (cnt_q == n_q - ONE);

      cnt_d  = cnt_q;
      n_d    = n_q;
      h_d    = h_q;
      sn_d   = sn_q;
      sh_d   = sh_q;
      pend_d = pend_q;
      err_d  = err_q;

      if (bus.cfg_load[g]) err_d = !ld_ok;

      if (run && !wrap) begin
        cnt_d = cnt_q + ONE;
        if (apply_ld) begin
          sn_d   = ld_n;
          sh_d   = ld_h;
          pend_d = 1'b1;
        end
      end else begin
        // Boundary, disable and sync all restart the period; a load arriving
        // here goes straight to active and beats any older shadow value.
        cnt_d  = '0;
        pend_d = 1'b0;
        if (apply_ld) begin
          n_d = ld_n;
          h_d = ld_h;
        end else if (pend_q) begin
          n_d = sn_q;
          h_d = sh_q;
        end
      end

      clk_d  = run && (cnt_d >= n_d - h_d);
      rise_d = run && (cnt_d == n_d - h_d);
      fall_d = run && wrap;
    end

    always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        n_q    <= DEF_N;
        h_q    <= DEF_H;
        sn_q   <= '0;
        sh_q   <= '0;
        pend_q <= 1'b0;
        err_q  <= 1'b0;
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        n_q    <= n_d;
        h_q    <= h_d;
        sn_q   <= sn_d;
        sh_q   <= sh_d;
        pend_q <= pend_d;
        err_q  <= err_d;
        clk_q  <= clk_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign bus.clk_out[g]   = clk_q;
    assign bus.rise_tick[g] = rise_q;
    assign bus.fall_tick[g] = fall_q;
    assign bus.cfg_pend[g]  = pend_q;
    assign bus.cfg_err[g]   = err_q;
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random traffic, every cycle
// compared against a period-level model of each channel.
module tb_clk_div_prog;
  localparam int NCH   = 2;
  localparam int CNT_W = 8;

  logic clk_50M = 1'b0;
  logic rst     = 1'b1;

  clk_div_prog_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  clk_div_prog #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(12), .DEF_HIGH(6)) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_50M = ~clk_50M;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: position in period, active/shadow config, status and output levels.
  int m_pos  [NCH];
  int m_n    [NCH];
  int m_h    [NCH];
  int m_sn   [NCH];
  int m_sh   [NCH];
  bit m_pend [NCH];
  bit m_err  [NCH];
  bit m_clk  [NCH];
  bit m_rise [NCH];
  bit m_fall [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i]  = 0;
      m_n[i]    = 12;
      m_h[i]    = 6;
      m_sn[i]   = 0;
      m_sh[i]   = 0;
      m_pend[i] = 0;
      m_err[i]  = 0;
      m_clk[i]  = 0;
      m_rise[i] = 0;
      m_fall[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < NCH; i++) begin
      int ln, lh;
      bit ld, ok, running, prev;
      ln      = int'(bus.div_ratio[i*CNT_W +: CNT_W]);
      lh      = int'(bus.high_cnt[i*CNT_W +: CNT_W]);
      ld      = bus.cfg_load[i];
      ok      = (ln >= 2) && (lh >= 1) && (lh <= ln - 1);
      running = bus.enable[i] && !bus.sync;
      prev    = m_clk[i];
      if (ld) m_err[i] = !ok;
      if (running && m_pos[i] < m_n[i] - 1) begin
        m_pos[i]++;
        if (ld && ok) begin
          m_sn[i]   = ln;
          m_sh[i]   = lh;
          m_pend[i] = 1;
        end
      end else begin
        m_pos[i] = 0;
        if (m_pend[i]) begin
          m_n[i] = m_sn[i];
          m_h[i] = m_sh[i];
        end
        m_pend[i] = 0;
        if (ld && ok) begin
          m_n[i] = ln;
          m_h[i] = lh;
        end
      end
      m_clk[i]  = running && (m_pos[i] >= m_n[i] - m_h[i]);
      m_rise[i] = m_clk[i] && !prev;
      m_fall[i] = prev && !m_clk[i] && running;
    end
  endfunction

  task automatic compare();
    logic [NCH-1:0] ec, er, ef, ep, ee;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = m_clk[i];
      er[i] = m_rise[i];
      ef[i] = m_fall[i];
      ep[i] = m_pend[i];
      ee[i] = m_err[i];
    end
    chk("clk_out",   32'(bus.clk_out),   32'(ec));
    chk("rise_tick", 32'(bus.rise_tick), 32'(er));
    chk("fall_tick", 32'(bus.fall_tick), 32'(ef));
    chk("cfg_pend",  32'(bus.cfg_pend),  32'(ep));
    chk("cfg_err",   32'(bus.cfg_err),   32'(ee));
  endtask

  task automatic step();
    @(posedge clk_50M);
    model_edge();
    #1;
    compare();
  endtask

  task automatic load(input int ch, input int n, input int h);
    bus.cfg_load[ch] = 1'b1;
    bus.div_ratio[ch*CNT_W +: CNT_W] = CNT_W'(n);
    bus.high_cnt[ch*CNT_W +: CNT_W]  = CNT_W'(h);
    step();
    bus.cfg_load[ch] = 1'b0;
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    @(negedge clk_50M);
    rst = 1'b0;
  endtask

  initial begin
    int k, nr, nf;
    bus.enable    = '0;
    bus.sync      = 1'b0;
    bus.cfg_load  = '0;
    bus.div_ratio = '0;
    bus.high_cnt  = '0;
    model_reset();

    repeat (2) @(posedge clk_50M);
    #1;
    compare();
    @(negedge clk_50M);
    rst = 1'b0;

    // Default 12/6 on both channels: two rises and two falls in 24 cycles.
    bus.enable = '1;
    nr = 0;
    nf = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      nr += int'(bus.rise_tick[0]);
      nf += int'(bus.fall_tick[0]);
    end
    chk("default_rises", 32'(nr), 32'd2);
    chk("default_falls", 32'(nf), 32'd2);

    // Mid-period load on ch0 waits for the boundary.
    for (k = 0; k < 40 && m_pos[0] != 3; k++) step();
    chk("reach_pos3", 32'(m_pos[0]), 32'd3);
    load(0, 5, 2);
    chk("pend_after_load", 32'(bus.cfg_pend[0]), 32'd1);
    repeat (30) step();

    // Rejected loads keep the old config; a good one clears the error.
    load(1, 1, 0);
    chk("err_n1", 32'(bus.cfg_err[1]), 32'd1);
    repeat (3) step();
    load(1, 8, 8);
    chk("err_h_eq_n", 32'(bus.cfg_err[1]), 32'd1);
    repeat (14) step();
    load(1, 8, 3);
    chk("err_cleared", 32'(bus.cfg_err[1]), 32'd0);
    repeat (30) step();

    // Sync with a pending ch0 config and a same-cycle ch1 load.
    for (k = 0; k < 20 && m_pos[0] != 1; k++) step();
    load(0, 12, 6);
    bus.sync = 1'b1;
    load(1, 12, 6);
    bus.sync = 1'b0;
    chk("sync_clk_low", 32'(bus.clk_out), 32'd0);
    chk("sync_pend_clr", 32'(bus.cfg_pend), 32'd0);
    for (int c = 0; c < 30; c++) begin
      step();
      chk("sync_rise_align", 32'(bus.rise_tick[0]), 32'(bus.rise_tick[1]));
    end

    // Drop ch0 enable in its high phase, then re-enable.
    for (k = 0; k < 30 && !m_clk[0]; k++) step();
    chk("reach_high", 32'(bus.clk_out[0]), 32'd1);
    bus.enable[0] = 1'b0;
    step();
    chk("dis_clk_low", 32'(bus.clk_out[0]), 32'd0);
    chk("dis_no_fall", 32'(bus.fall_tick[0]), 32'd0);
    bus.enable[0] = 1'b1;
    for (k = 1; k <= 20; k++) begin
      step();
      if (bus.rise_tick[0]) break;
    end
    chk("reenable_low_cycles", 32'(k), 32'd6);

    // Async reset during a high phase with a pending config.
    for (k = 0; k < 30 && m_pos[0] != 6; k++) step();
    load(0, 10, 4);
    chk("pend_before_rst", 32'(bus.cfg_pend[0]), 32'd1);
    async_reset();
    repeat (30) step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        int ln;
        if ($urandom_range(0, 49) == 0) bus.enable[i] = ~bus.enable[i];
        bus.cfg_load[i] = ($urandom_range(0, 14) == 0);
        ln = int'($urandom_range(0, 15));
        bus.div_ratio[i*CNT_W +: CNT_W] = CNT_W'(ln);
        bus.high_cnt[i*CNT_W +: CNT_W]  = CNT_W'($urandom_range(0, ln));
      end
      bus.sync = ($urandom_range(0, 59) == 0);
      step();
      if (c == 1500) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel programmable clock-enable/divided-clock generator.
- Successor to the fixed divide-by-12 divider. Adds the following, per channel:
  - runtime-loadable divide ratio and high time;
  - glitch-free ratio update at period boundaries;
  - enable control;
  - rise/fall tick strobes.
- Adds a common phase-sync input that aligns all channels.
- Sits beside the main FSM. Feeds derived sample/shift clocks and single-cycle strobes to downstream blocks, all in the clk_50M domain.

Parameters:
- NCH, 2: number of independent divider channels.
- CNT_W, 8: counter and config field width. Max ratio is 2^CNT_W-1.
- DEF_DIV, 12: divide ratio N loaded at reset.
- DEF_HIGH, 6: high-time H (in clk_50M cycles) loaded at reset.

Ports:
- clk_50M, input, 1: system clock.
- rst, input, 1: reset. Asynchronous, active-high.
- enable, input, NCH: per-channel run enable.
- sync, input, 1: synchronous phase restart of all channels.
- cfg_load, input, NCH: per-channel one-cycle config strobe.
- div_ratio, input, NCH*CNT_W: packed N per channel. Channel i occupies bits [i*CNT_W +: CNT_W].
- high_cnt, input, NCH*CNT_W: packed H per channel, same packing.
- clk_out, output, NCH: registered divided clock.
- rise_tick, output, NCH: one-cycle pulse on the clk_out 0→1 cycle.
- fall_tick, output, NCH: one-cycle pulse on the clk_out 1→0 cycle.
- cfg_pend, output, NCH: shadow config waiting for the period boundary.
- cfg_err, output, NCH: last load was rejected.

Behaviour:
- Reset (async on rst high): all channels are cleared as follows.
  - cnt=0, active N=DEF_DIV, active H=DEF_HIGH.
  - Shadow registers cleared; cfg_pend=0, cfg_err=0.
  - clk_out=0, rise_tick=0, fall_tick=0.
  - Reset mid-period aborts immediately, with no tail pulse.
- Counting (enable[i]=1):
  - cnt runs 0..N-1, then wraps to 0.
  - clk_out is registered and equals 1 exactly in cycles where the registered cnt ≥ N-H.
  - Each period is N-H cycles low followed by H cycles high, starting low.
- Ticks:
  - rise_tick=1 in the cycle where cnt==N-H, i.e. the first high cycle.
  - fall_tick=1 in the cycle where cnt==0 after a wrap from N-1.
  - No fall_tick on the first cycle after reset, enable rising, or sync.
- Disable (enable[i]=0):
  - cnt held at 0, clk_out=0, ticks=0.
  - Disabling mid-high forces clk_out low next cycle, with no fall_tick.
  - Re-enable starts at cnt=0, i.e. a low phase.
- Config validity:
  - Valid iff N≥2 and 1≤H≤N-1.
  - Invalid load: cfg_err[i]=1 next cycle; shadow and active config unchanged; any pending config is kept.
  - A valid load clears cfg_err[i] next cycle.
- Config apply:
  - A valid cfg_load captures the value into the shadow and sets cfg_pend.
  - The shadow moves to active at the boundary, i.e. the cycle with cnt==N-1 (old N), so the next period (cnt=0) uses the new N/H.
  - cfg_pend clears in that same transfer cycle.
  - If cfg_load arrives in the boundary cycle itself, the new config bypasses the shadow and applies from the next cnt=0; cfg_pend is never set.
  - A second load before the boundary overwrites the shadow (last wins).
  - When the channel is disabled, a valid load applies to active immediately; cfg_pend stays 0.
- Sync:
  - Forces cnt=0 and clk_out=0 on all enabled channels next cycle.
  - Pending shadows are applied at that point and cfg_pend is cleared.
  - No tick is generated in the sync cycle.
  - sync together with cfg_load: the new config is applied and the period starts from 0.
- Width: counters are CNT_W bits; the comparison N-H uses CNT_W-bit unsigned arithmetic, guaranteed non-negative by the validity rule.
- Latency: outputs are registered; one clk_50M cycle from any input to its effect.

Test Plan:
- Reset release, enable=all 1s → each clk_out repeats 6 low then 6 high (period 12). rise_tick at cycles 6, 18, … after enable; fall_tick at 12, 24, ….
- Load ch0 N=5, H=2 at cnt=3 → cfg_pend=1. Current 12-cycle period completes, then clk_out repeats 3 low/2 high. cfg_pend drops at cnt=11. Ch1 is unaffected.
- Load ch1 N=1, H=0, then N=8, H=8 → cfg_err=1 after each load, and the period stays 12. A following load of N=8, H=3 clears cfg_err and yields 5 low/3 high.
- Channels at different phases; pulse sync → both clk_out are low with cnt=0 next cycle, and their rise_ticks are coincident thereafter (equal configs). A pending config applies immediately at sync.
- enable ch0 dropped during the high phase → clk_out=0 next cycle, no fall_tick. Re-enable → 6 low cycles precede the next rise_tick.
- rst asserted mid-high-phase with a pending config → all outputs are 0 immediately. After release, N=12/H=6 is active and cfg_pend=0.
